// File: rtl/down_counter_sync.sv
// Synchronous loadable down-counter with registered one-cycle terminal-count pulse.
// Define DOWN_COUNTER_RELOAD_EN for auto-reload mode; default build is one-shot.
module down_counter_sync #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   output logic [WIDTH-1:0] Q,
   output logic             tc,
   output logic             busy
);

   localparam logic [WIDTH-1:0] One  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] Zero = '0;

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] rld_q, rld_d;
   logic             tc_q, tc_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= Zero;
         rld_q   <= Zero;
         tc_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rld_q   <= rld_d;
         tc_q    <= tc_d;
      end
   end

   // Load wins over enable; a decrement coinciding with a load is dropped.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rld_d   = rld_q;
      tc_d    = 1'b0;
      if (load) begin
         cnt_d   = load_val;
         rld_d   = load_val;
         state_d = (load_val != Zero) ? StRun : StIdle;
      end else if (state_q == StRun && en) begin
         if (cnt_q > One) begin
            cnt_d = cnt_q - One;
         end else begin
            tc_d = 1'b1;
`ifdef DOWN_COUNTER_RELOAD_EN
            cnt_d = rld_q;
`else
            cnt_d   = Zero;
            state_d = StIdle;
`endif
         end
      end
   end

`ifndef DOWN_COUNTER_RELOAD_EN
   // Reload value is only consumed in auto-reload builds.
   logic unused_rld;
   assign unused_rld = ^rld_q;
`endif

   assign Q    = cnt_q;
   assign tc   = tc_q;
   assign busy = (state_q == StRun);

endmodule

// File: tb/tb_down_counter_sync.sv
// Scoreboard bench for down_counter_sync: directed scenarios plus random load/enable traffic.
module tb_down_counter_sync;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         load;
   logic [W-1:0] load_val;
   logic         en;
   logic [W-1:0] Q;
   logic         tc;
   logic         busy;

   down_counter_sync #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (load_val),
      .en       (en),
      .Q        (Q),
      .tc       (tc),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int    q;
      bit    tc;
      bit    busy;
      string name;
   } exp_t;

   exp_t exp_q[$];
   event sample_ev;
   int   checks   = 0;
   int   failures = 0;

   // Reference model: remaining count, reload value, running flag, pulse.
   int m_count = 0;
   int m_rld   = 0;
   bit m_run   = 0;
   bit m_tc    = 0;

   function automatic void model_reset();
      m_count = 0;
      m_rld   = 0;
      m_run   = 0;
      m_tc    = 0;
   endfunction

   function automatic void model_edge(bit ld, int lv, bit e);
      m_tc = 0;
      if (ld) begin
         m_count = lv;
         m_rld   = lv;
         m_run   = (lv != 0);
      end else if (m_run && e) begin
         if (m_count >= 2) begin
            m_count = m_count - 1;
         end else begin
            m_tc = 1;
`ifdef DOWN_COUNTER_RELOAD_EN
            m_count = m_rld;
`else
            m_count = 0;
            m_run   = 0;
`endif
         end
      end
   endfunction

   task automatic push_exp(string name);
      exp_t x;
      x.q    = m_count;
      x.tc   = m_tc;
      x.busy = m_run;
      x.name = name;
      exp_q.push_back(x);
      -> sample_ev;
   endtask

   // Drive on the falling edge, advance the model on the rising edge, check 1 time unit later.
   task automatic step(bit ld, int lv, bit e, string name);
      @(negedge clk);
      load     = ld;
      load_val = W'(lv);
      en       = e;
      @(posedge clk);
      if (rst) model_reset();
      else model_edge(ld, lv, e);
      #1;
      push_exp(name);
   endtask

   initial begin : monitor
      exp_t x;
      forever begin
         @(sample_ev);
         while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            checks++;
            if (int'(Q) !== x.q || tc !== x.tc || busy !== x.busy) begin
               failures++;
               $display("FAIL %s: got Q=%0d tc=%0b busy=%0b, want Q=%0d tc=%0b busy=%0b",
                        x.name, Q, tc, busy, x.q, x.tc, x.busy);
            end
         end
      end
   end

   initial begin : stimulus
      rst      = 1'b1;
      load     = 1'b0;
      load_val = '0;
      en       = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      #1 push_exp("reset_state");
      @(negedge clk);
      rst = 1'b0;
      step(0, 0, 1, "idle_en_ignored");

      // One-shot / auto-reload countdown from 3
      step(1, 3, 1, "load3");
      for (int i = 0; i < 13; i++) step(0, 0, 1, "count3");

      // Enable gaps
      step(1, 2, 0, "gap_load");
      step(0, 0, 1, "gap_en1");
      step(0, 0, 0, "gap_en0a");
      step(0, 0, 0, "gap_en0b");
      step(0, 0, 1, "gap_en1b");
      step(0, 0, 0, "gap_after");

      // Load beats a terminal decrement
      step(1, 1, 0, "prio_load1");
      step(1, 9, 1, "prio_load9");
      step(0, 0, 1, "prio_after");

      // Zero load, then full scale
      step(1, 0, 1, "load0");
      step(0, 0, 1, "load0_en");
      step(1, 15, 0, "load15");
      for (int i = 0; i < 18; i++) step(0, 0, 1, "count15");

      // Asynchronous reset mid-cycle with Q=5
      step(1, 5, 0, "pre_rst_load5");
      @(negedge clk);
      en = 1'b1;
      load = 1'b0;
      #2 rst = 1'b1;
      #1;
      model_reset();
      push_exp("async_rst");
      step(0, 0, 1, "rst_held");
      @(negedge clk);
      rst = 1'b0;
      step(0, 0, 1, "post_rst_en1");
      step(0, 0, 1, "post_rst_en2");

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 9) == 0), int'($urandom_range(0, 15)),
              ($urandom_range(0, 3) != 0), "random");
      end

      #2;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending, want 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
